sprite_blitter: RTL and testbench

- Avalon-MM-programmable sprite pixel engine; sits between vga_controller (DrawX/DrawY/blank/vs) and the VGA colour outputs.
- Fetches palette indices from an external synchronous sprite RAM with configurable latency, then maps them through a writable palette to 12-bit RGB.
- Generalised in sprite size, palette depth, frame count and RAM latency.
- Adds transparency, horizontal flip, vsync-latched (tear-free) position/frame updates and automatic frame animation.

---
 rtl/sprite_blitter.sv | 236 +++++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Avalon-MM programmable sprite engine placed between the VGA timing
//   generator and the colour outputs. Palette indices are fetched from an
//   external synchronous sprite RAM and mapped through a writable palette
//   to 12-bit RGB. Supports transparency, horizontal flip, vsync-latched
//   position/frame updates and automatic frame animation.
//
// Ports
//   CLK, RESET              system clock, synchronous active-high reset
//   AVL_*                   Avalon-MM slave (one-cycle writes, registered reads)
//   DRAW_X/DRAW_Y/BLANK     current raster position, BLANK high = visible
//   VSYNC                   vertical sync from the timing generator
//   SPR_ADDR/SPR_DATA       sprite RAM read port, data RAM_LAT cycles after address
//   RED/GREEN/BLUE          pixel colour, PIX_VALID high on opaque sprite pixels
//
// Register map (word address)
//   0 CTRL    [0] enable [1] anim_en [2] hflip [8+:PAL_BITS] transparent index
//   1 POS     [9:0] X [25:16] Y (shadow, loaded on vsync)
//   2 FRAME   [7:0] frame (write shadow, read active) [31:24] anim period
//   3 STATUS  [15:0] vsync count [16] frame write pending
//   8..       PALETTE [11:0] RGB 4:4:4
module sprite_blitter #(
    parameter int SPR_W      = 60,
    parameter int SPR_H      = 60,
    parameter int NUM_FRAMES = 4,
    parameter int PAL_BITS   = 3,
    parameter int RAM_LAT    = 1,
    parameter int ADDR_W     = 17
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic                AVL_CS,
    input  logic [3:0]          AVL_BYTE_EN,
    input  logic [4:0]          AVL_ADDR,
    input  logic [31:0]         AVL_WRITEDATA,
    output logic [31:0]         AVL_READDATA,
    input  logic [9:0]          DRAW_X,
    input  logic [9:0]          DRAW_Y,
    input  logic                BLANK,
    input  logic                VSYNC,
    output logic [ADDR_W-1:0]   SPR_ADDR,
    input  logic [PAL_BITS-1:0] SPR_DATA,
    output logic [3:0]          RED,
    output logic [3:0]          GREEN,
    output logic [3:0]          BLUE,
    output logic                PIX_VALID
);

    localparam int NPAL = 1 << PAL_BITS;
    localparam logic [5:0]        PAL_END    = 6'(8 + NPAL);
    localparam logic [10:0]       SPR_W11    = 11'(SPR_W);
    localparam logic [10:0]       SPR_H11    = 11'(SPR_H);
    localparam logic [8:0]        NF9        = 9'(NUM_FRAMES);
    localparam logic [ADDR_W-1:0] FRAME_SZ_A = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] SPR_W_A    = ADDR_W'(SPR_W);

    // Saturate a written frame number to the last stored frame.
    function automatic logic [7:0] clamp_frame(input logic [7:0] f);
        if ({1'b0, f} >= NF9) return 8'(NUM_FRAMES - 1);
        return f;
    endfunction

    function automatic logic [7:0] next_frame(input logic [7:0] f);
        if (f == 8'(NUM_FRAMES - 1)) return 8'd0;
        return f + 8'd1;
    endfunction

    logic                ctrl_en, ctrl_anim, ctrl_hflip;
    logic [PAL_BITS-1:0] trans_idx;
    logic [9:0]          shadow_x, shadow_y, act_x, act_y;
    logic [7:0]          shadow_frame, act_frame, anim_period, anim_cnt;
    logic                frame_pend;
    logic [15:0]         vs_cnt;
    logic                vs_prev;
    logic [11:0]         palette [NPAL];

    logic                vs_edge, wr_en, rd_en, pal_hit;
    logic [PAL_BITS-1:0] pal_sel;
    logic [31:0]         rd_mux;
    logic                unused_wd;

    assign vs_edge   = VSYNC & ~vs_prev;
    assign wr_en     = AVL_WRITE & AVL_CS;
    assign rd_en     = AVL_READ & AVL_CS;
    assign pal_hit   = (AVL_ADDR >= 5'd8) && ({1'b0, AVL_ADDR} < PAL_END);
    assign pal_sel   = PAL_BITS'(AVL_ADDR - 5'd8);
    assign unused_wd = ^AVL_WRITEDATA[15:12];

    always_comb begin
        rd_mux = '0;
        case (AVL_ADDR)
            5'd0: begin
                rd_mux[2:0]           = {ctrl_hflip, ctrl_anim, ctrl_en};
                rd_mux[8 +: PAL_BITS] = trans_idx;
            end
            5'd1: begin
                rd_mux[9:0]   = shadow_x;
                rd_mux[25:16] = shadow_y;
            end
            5'd2: begin
                rd_mux[7:0]   = act_frame;
                rd_mux[31:24] = anim_period;
            end
            5'd3: begin
                rd_mux[15:0] = vs_cnt;
                rd_mux[16]   = frame_pend;
            end
            default: begin
                if (pal_hit) rd_mux[11:0] = palette[pal_sel];
            end
        endcase
    end

    // Register file, vsync-latched state and Avalon read port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_en      <= 1'b0;
            ctrl_anim    <= 1'b0;
            ctrl_hflip   <= 1'b0;
            trans_idx    <= '0;
            shadow_x     <= '0;
            shadow_y     <= '0;
            act_x        <= '0;
            act_y        <= '0;
            shadow_frame <= '0;
            act_frame    <= '0;
            anim_period  <= '0;
            anim_cnt     <= '0;
            frame_pend   <= 1'b0;
            vs_cnt       <= '0;
            vs_prev      <= 1'b0;
            AVL_READDATA <= '0;
            for (int i = 0; i < NPAL; i++) palette[i] <= '0;
        end else begin
            vs_prev <= VSYNC;

            if (vs_edge) begin
                vs_cnt <= vs_cnt + 16'd1;
                act_x  <= shadow_x;
                act_y  <= shadow_y;
                if (frame_pend) begin
                    act_frame  <= shadow_frame;
                    frame_pend <= 1'b0;
                    anim_cnt   <= '0;
                end else if (ctrl_anim && (anim_period != 8'd0)) begin
                    if (anim_cnt == anim_period - 8'd1) begin
                        anim_cnt  <= '0;
                        act_frame <= next_frame(act_frame);
                    end else begin
                        anim_cnt <= anim_cnt + 8'd1;
                    end
                end
            end

            // Placed after the vsync block so a FRAME write landing on the
            // edge re-arms pending for the following edge.
            if (wr_en) begin
                case (AVL_ADDR)
                    5'd0: begin
                        if (AVL_BYTE_EN[0]) {ctrl_hflip, ctrl_anim, ctrl_en} <= AVL_WRITEDATA[2:0];
                        if (AVL_BYTE_EN[1]) trans_idx <= AVL_WRITEDATA[8 +: PAL_BITS];
                    end
                    5'd1: begin
                        if (AVL_BYTE_EN[0]) shadow_x[7:0] <= AVL_WRITEDATA[7:0];
                        if (AVL_BYTE_EN[1]) shadow_x[9:8] <= AVL_WRITEDATA[9:8];
                        if (AVL_BYTE_EN[2]) shadow_y[7:0] <= AVL_WRITEDATA[23:16];
                        if (AVL_BYTE_EN[3]) shadow_y[9:8] <= AVL_WRITEDATA[25:24];
                    end
                    5'd2: begin
                        if (AVL_BYTE_EN[0]) begin
                            shadow_frame <= clamp_frame(AVL_WRITEDATA[7:0]);
                            frame_pend   <= 1'b1;
                        end
                        if (AVL_BYTE_EN[3]) anim_period <= AVL_WRITEDATA[31:24];
                    end
                    default: begin
                        if (pal_hit) begin
                            if (AVL_BYTE_EN[0]) palette[pal_sel][7:0]  <= AVL_WRITEDATA[7:0];
                            if (AVL_BYTE_EN[1]) palette[pal_sel][11:8] <= AVL_WRITEDATA[11:8];
                        end
                    end
                endcase
            end

            if (rd_en) AVL_READDATA <= rd_mux;
        end
    end

    // S0: hit test and address generation. A negative offset wraps to a
    // large 11-bit value and fails the bounds check, which also clips at
    // the right screen edge.
    logic [10:0]       dx, dy, col;
    logic              hit;
    logic [ADDR_W-1:0] addr_calc;

    assign dx        = {1'b0, DRAW_X} - {1'b0, act_x};
    assign dy        = {1'b0, DRAW_Y} - {1'b0, act_y};
    assign hit       = BLANK && ctrl_en && (dx < SPR_W11) && (dy < SPR_H11);
    assign col       = ctrl_hflip ? (SPR_W11 - 11'd1 - dx) : dx;
    assign addr_calc = ADDR_W'(act_frame) * FRAME_SZ_A + ADDR_W'(dy) * SPR_W_A + ADDR_W'(col);

    logic               vld_p0;
    logic [RAM_LAT-1:0] vld_p1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SPR_ADDR  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= '0;
            RED       <= '0;
            GREEN     <= '0;
            BLUE      <= '0;
            PIX_VALID <= 1'b0;
        end else begin
            // S0 -> S1: address to sprite RAM
            vld_p0   <= hit;
            SPR_ADDR <= hit ? addr_calc : '0;

            // S1..S(RAM_LAT): hit follows the RAM read latency
            vld_p1[0] <= vld_p0;
            for (int i = 1; i < RAM_LAT; i++) vld_p1[i] <= vld_p1[i-1];

            // final stage: palette lookup and transparency
            if (vld_p1[RAM_LAT-1] && (SPR_DATA != trans_idx)) begin
                {RED, GREEN, BLUE} <= palette[SPR_DATA];
                PIX_VALID          <= 1'b1;
            end else begin
                {RED, GREEN, BLUE} <= 12'd0;
                PIX_VALID          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
    logic [3:0]  AVL_BYTE_EN = 4'h0;
    logic [4:0]  AVL_ADDR = 5'd0;
    logic [31:0] AVL_WRITEDATA = 32'd0;
    logic [31:0] AVL_READDATA;
    logic [9:0]  DRAW_X = 10'd0, DRAW_Y = 10'd0;
    logic        BLANK = 1'b0, VSYNC = 1'b0;
    logic [16:0] SPR_ADDR;
    logic [2:0]  spr_data = 3'd0;
    logic [3:0]  RED, GREEN, BLUE;
    logic        PIX_VALID;

    int n_cmp = 0;
    int n_bad = 0;
    int vs_total = 0;

    sprite_blitter dut (
        .CLK(CLK), .RESET(RESET),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y), .BLANK(BLANK), .VSYNC(VSYNC),
        .SPR_ADDR(SPR_ADDR), .SPR_DATA(spr_data),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .PIX_VALID(PIX_VALID)
    );

    always #10 CLK = ~CLK;

    // Sprite RAM, one-cycle latency: word at address a holds (a+2) mod 8.
    always @(posedge CLK) spr_data <= 3'(SPR_ADDR + 17'd2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic avl_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        AVL_WRITE = 1'b1; AVL_CS = 1'b1;
        tick();
        AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        AVL_ADDR = a; AVL_READ = 1'b1; AVL_CS = 1'b1;
        tick();
        AVL_READ = 1'b0; AVL_CS = 1'b0;
        chk(tag, AVL_READDATA, exp);
    endtask

    task automatic vsync();
        VSYNC = 1'b1; tick();
        VSYNC = 1'b0; tick();
        vs_total++;
    endtask

    // Flush, then present one raster position and follow it down the pipe.
    task automatic probe(input string tag, input int x, input int y, input logic blk,
                         input int exp_addr, input logic exp_pv, input logic [11:0] exp_rgb);
        BLANK = 1'b0;
        repeat (3) tick();
        DRAW_X = 10'(x); DRAW_Y = 10'(y); BLANK = blk;
        tick();
        chk({tag, ".addr"}, 32'(SPR_ADDR), 32'(exp_addr));
        tick();
        chk({tag, ".early"}, 32'(PIX_VALID), 32'd0);
        tick();
        chk({tag, ".pv"}, 32'(PIX_VALID), 32'(exp_pv));
        chk({tag, ".rgb"}, 32'({RED, GREEN, BLUE}), 32'(exp_rgb));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] anim_exp [8];
        anim_exp = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0};

        repeat (2) tick();
        RESET = 1'b0;
        chk("rst_rdata", AVL_READDATA, 32'd0);
        chk("rst_addr", 32'(SPR_ADDR), 32'd0);
        chk("rst_pv", 32'(PIX_VALID), 32'd0);
        chk("rst_rgb", 32'({RED, GREEN, BLUE}), 32'd0);
        rd_chk("rst_ctrl", 5'd0, 32'd0);
        rd_chk("rst_pos", 5'd1, 32'd0);
        rd_chk("rst_frame", 5'd2, 32'd0);
        rd_chk("rst_status", 5'd3, 32'd0);
        rd_chk("rst_pal5", 5'd13, 32'd0);

        // byte enables and read-data hold
        avl_wr(5'd13, 32'h0000_0FFF, 4'b0001);
        rd_chk("pal5_be", 5'd13, 32'h0000_00FF);
        tick();
        chk("rdata_hold", AVL_READDATA, 32'h0000_00FF);
        avl_wr(5'd4, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("unmapped", 5'd4, 32'd0);

        avl_wr(5'd9,  32'h0000_07E1, 4'b0011);
        avl_wr(5'd10, 32'h0000_0A5C, 4'b0011);
        avl_wr(5'd11, 32'h0000_0123, 4'b0011);
        rd_chk("pal2", 5'd10, 32'h0000_0A5C);

        // position is held in shadow until vsync
        avl_wr(5'd1, (32'd50 << 16) | 32'd100, 4'b1111);
        avl_wr(5'd0, 32'h0000_0701, 4'b0011);
        rd_chk("pos_shadow", 5'd1, 32'h0032_0064);
        probe("pre_vs", 100, 50, 1'b1, 0, 1'b0, 12'h000);

        vsync();
        probe("origin", 100, 50, 1'b1, 0, 1'b1, 12'hA5C);
        probe("next_px", 101, 50, 1'b1, 1, 1'b1, 12'h123);
        probe("left_out", 99, 50, 1'b1, 0, 1'b0, 12'h000);
        probe("right_out", 160, 50, 1'b1, 0, 1'b0, 12'h000);
        probe("blanked", 100, 50, 1'b0, 0, 1'b0, 12'h000);

        // transparency
        avl_wr(5'd0, 32'h0000_0301, 4'b0011);
        probe("transp", 101, 50, 1'b1, 1, 1'b0, 12'h000);
        probe("opaque", 100, 50, 1'b1, 0, 1'b1, 12'hA5C);

        // horizontal flip at the origin
        avl_wr(5'd1, 32'd0, 4'b1111);
        vsync();
        avl_wr(5'd0, 32'h0000_0305, 4'b0011);
        probe("hflip", 0, 0, 1'b1, 59, 1'b1, 12'h0FF);

        // frame select through the pending path
        avl_wr(5'd0, 32'h0000_0301, 4'b0011);
        avl_wr(5'd2, 32'd2, 4'b0001);
        rd_chk("status_pend", 5'd3, {15'd0, 1'b1, 16'(vs_total)});
        vsync();
        rd_chk("frame2", 5'd2, 32'd2);
        probe("frame2_px", 3, 1, 1'b1, 2*3600 + 60 + 3, 1'b1, 12'h7E1);

        // animation, period 2
        avl_wr(5'd2, 32'h0200_0000, 4'b1001);
        avl_wr(5'd0, 32'h0000_0303, 4'b0011);
        vsync();
        rd_chk("anim_load", 5'd2, 32'h0200_0000);
        for (int i = 0; i < 8; i++) begin
            vsync();
            rd_chk($sformatf("anim%0d", i), 5'd2, {8'h02, 16'd0, anim_exp[i]});
        end

        // frame write on the vsync edge, clamped value
        VSYNC = 1'b1;
        AVL_ADDR = 5'd2; AVL_WRITEDATA = 32'd9; AVL_BYTE_EN = 4'b0001;
        AVL_WRITE = 1'b1; AVL_CS = 1'b1;
        tick();
        AVL_WRITE = 1'b0; AVL_CS = 1'b0; VSYNC = 1'b0;
        tick();
        vs_total++;
        rd_chk("edge_wr_pend", 5'd3, {15'd0, 1'b1, 16'(vs_total)});
        rd_chk("edge_wr_frame", 5'd2, 32'h0200_0000);
        vsync();
        rd_chk("clamp_frame", 5'd2, 32'h0200_0003);
        rd_chk("pend_clear", 5'd3, 32'(vs_total));

        // right-edge clipping, frame 3
        avl_wr(5'd0, 32'h0000_0301, 4'b0011);
        avl_wr(5'd1, 32'd1000, 4'b1111);
        vsync();
        rd_chk("pos_1000", 5'd1, 32'd1000);
        probe("clip_1023", 1023, 0, 1'b1, 3*3600 + 23, 1'b1, 12'h7E1);
        probe("clip_x0", 0, 0, 1'b1, 0, 1'b0, 12'h000);
        probe("clip_x35", 35, 0, 1'b1, 0, 1'b0, 12'h000);
        probe("clip_1000", 1000, 0, 1'b1, 3*3600, 1'b1, 12'hA5C);

        // reset in the middle of a lit run
        RESET = 1'b1;
        tick();
        chk("mid_rst_pv", 32'(PIX_VALID), 32'd0);
        chk("mid_rst_rgb", 32'({RED, GREEN, BLUE}), 32'd0);
        chk("mid_rst_addr", 32'(SPR_ADDR), 32'd0);
        chk("mid_rst_rdata", AVL_READDATA, 32'd0);
        RESET = 1'b0;
        tick();
        rd_chk("post_rst_ctrl", 5'd0, 32'd0);
        rd_chk("post_rst_pal2", 5'd10, 32'd0);
        rd_chk("post_rst_frame", 5'd2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
